// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
// Optional starvation guard is enabled by MEM_ARB_STARVE_GUARD_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_D = 2'd1,
        WAIT_I = 2'd2
    } arb_state_e;

    localparam int STARVE_MAX_DEF = 4;

    localparam logic SEL_DATA  = 1'b0;
    localparam logic SEL_FETCH = 1'b1;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts data grants taken while a fetch waits; raises force_fetch at the limit.
// Only instantiated when MEM_ARB_STARVE_GUARD_EN is defined.
module arb_starve_ctr #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic data_grant,
    input  logic fetch_grant,
    output logic force_fetch
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (fetch_grant) begin
            cnt_d = '0;
        end else if (data_grant && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_fetch = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shared IF/MEM memory port arbiter, one outstanding transaction, data priority.
// Define MEM_ARB_STARVE_GUARD_EN to bound fetch wait after STARVE_MAX data grants.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              mem_stall,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata
);

    arb_state_e state_q, state_d;
    logic       drop_q, drop_d;

    logic d_pend;
    logic i_pend;
    logic force_fetch;
    logic sel;
    logic grant;
    logic accept;
    logic rsp;

    always_comb begin
        d_pend = mem_read | mem_write;
        i_pend = if_req & ~if_flush;
        grant  = (state_q == IDLE) & (d_pend | i_pend) & ~rst;
        sel    = (i_pend & (~d_pend | force_fetch)) ? SEL_FETCH : SEL_DATA;
        accept = grant & m_ready;
        rsp    = m_rvalid & ~rst;
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    arb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .data_grant (accept & (sel == SEL_DATA) & i_pend),
        .fetch_grant(accept & (sel == SEL_FETCH)),
        .force_fetch(force_fetch)
    );
`else
    // Strict data priority: never force a fetch.
    assign force_fetch = (STARVE_MAX < 0);
`endif

    always_comb begin
        m_req   = grant;
        m_we    = grant & (sel == SEL_DATA) & mem_write;
        m_addr  = '0;
        m_wdata = '0;
        if (grant) begin
            m_addr  = (sel == SEL_DATA) ? mem_addr : if_addr;
            m_wdata = (sel == SEL_DATA) ? mem_wdata : '0;
        end
    end

    always_comb begin
        mem_done  = (state_q == WAIT_D) & rsp;
        if_valid  = (state_q == WAIT_I) & rsp & ~drop_q & ~if_flush;
        mem_rdata = mem_done ? m_rdata : '0;
        if_rdata  = if_valid ? m_rdata : '0;
        mem_stall = d_pend & ~mem_done;
        if_stall  = if_req & ~if_valid;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (sel == SEL_FETCH) ? WAIT_I : WAIT_D;
                end
            end
            WAIT_D, WAIT_I: begin
                if (m_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A flushed fetch still owns the port; its response is swallowed.
    assign drop_d = (state_q == WAIT_I) & ~m_rvalid & (drop_q | if_flush);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a fixed-latency memory model.
// Starvation expectations follow MEM_ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, mem_read, mem_write, m_ready;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [31:0] if_rdata, mem_rdata, m_addr, m_wdata, m_rdata;
    logic        if_valid, if_stall, mem_done, mem_stall;
    logic        m_req, m_we, m_rvalid;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    function automatic logic [31:0] mdat(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory model: accepts when idle, answers LAT cycles after issue.
    logic        busy = 1'b0;
    int          age = 0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_we = 1'b0;

    always @(posedge clk) begin
        if (busy) begin
            if (age == LAT) busy <= 1'b0;
            else age <= age + 1;
        end else if (m_req && m_ready) begin
            busy      <= 1'b1;
            age       <= 1;
            req_addr  <= m_addr;
            req_we    <= m_we;
            req_wdata <= m_wdata;
        end
    end

    assign m_rvalid = busy && (age == LAT);
    assign m_rdata  = mdat(req_addr);

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        fetch;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];

    always @(negedge clk) begin
        exp_t e;
        if (if_valid || mem_done) begin
            if (q.size() == 0) begin
                check("spurious_done", {30'b0, if_valid, mem_done}, 32'h0);
            end else begin
                e = q.pop_front();
                check("kind", {31'b0, if_valid}, {31'b0, e.fetch});
                check("rdata", if_valid ? if_rdata : mem_rdata, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic exp_t mk(input logic f, input logic [31:0] a);
        exp_t e;
        e.fetch = f;
        e.data  = mdat(a);
        return e;
    endfunction

    int fetch_cyc;
    int fetch_exp;

    initial begin
        rst = 1'b1;
        if_req = 0; if_flush = 0; mem_read = 0; mem_write = 0;
        m_ready = 1; if_addr = '0; mem_addr = '0; mem_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        smp();
        check("rst_m_req", {31'b0, m_req}, 0);
        check("rst_if_valid", {31'b0, if_valid}, 0);
        check("rst_mem_done", {31'b0, mem_done}, 0);
        check("rst_stalls", {30'b0, if_stall, mem_stall}, 0);

        // Lone fetch
        step(); if_req = 1; if_addr = 32'h100; q.push_back(mk(1, 32'h100));
        smp();
        check("f_req", {31'b0, m_req}, 1);
        check("f_addr", m_addr, 32'h100);
        check("f_we", {31'b0, m_we}, 0);
        check("f_stall0", {31'b0, if_stall}, 1);
        step(); smp();
        check("f_req1", {31'b0, m_req}, 0);
        check("f_stall1", {31'b0, if_stall}, 1);
        step(); smp();
        check("f_valid", {31'b0, if_valid}, 1);
        check("f_stall2", {31'b0, if_stall}, 0);
        step(); if_req = 0; smp();
        check("f_nodup", {31'b0, m_req}, 0);

        // Data and fetch contend
        step();
        mem_read = 1; mem_addr = 32'h200; if_req = 1; if_addr = 32'h104;
        q.push_back(mk(0, 32'h200)); q.push_back(mk(1, 32'h104));
        smp();
        check("c_req", {31'b0, m_req}, 1);
        check("c_addr", m_addr, 32'h200);
        check("c_stalls", {30'b0, if_stall, mem_stall}, 32'h3);
        step(); smp();
        check("c_wait", {31'b0, m_req}, 0);
        step(); smp();
        check("c_done", {31'b0, mem_done}, 1);
        check("c_mstall", {31'b0, mem_stall}, 0);
        check("c_noreq", {31'b0, m_req}, 0);
        step(); mem_read = 0; smp();
        check("c_freq", {31'b0, m_req}, 1);
        check("c_faddr", m_addr, 32'h104);
        step(); step(); smp();
        check("c_fvalid", {31'b0, if_valid}, 1);
        step(); if_req = 0;

        // Write with back-pressure
        mem_write = 1; mem_addr = 32'h300; mem_wdata = 32'hDEADBEEF;
        m_ready = 0; q.push_back(mk(0, 32'h300));
        for (int i = 0; i < 3; i++) begin
            smp();
            check("w_req", {31'b0, m_req}, 1);
            check("w_we", {31'b0, m_we}, 1);
            check("w_addr", m_addr, 32'h300);
            check("w_data", m_wdata, 32'hDEADBEEF);
            check("w_nodone", {31'b0, mem_done}, 0);
            step();
        end
        m_ready = 1; smp();
        check("w_acc", {31'b0, m_req}, 1);
        step(); smp();
        check("w_done_early", {31'b0, mem_done}, 0);
        step(); smp();
        check("w_done", {31'b0, mem_done}, 1);
        check("w_mem_we", {31'b0, req_we}, 1);
        check("w_mem_data", req_wdata, 32'hDEADBEEF);
        step(); mem_write = 0; smp();
        check("w_idle", {31'b0, m_req}, 0);

        // Flush during fetch wait
        step(); if_req = 1; if_addr = 32'h400; smp();
        check("fl_addr", m_addr, 32'h400);
        step(); if_flush = 1; smp();
        check("fl_wait", {31'b0, m_req}, 0);
        step(); if_flush = 0; if_addr = 32'h500; q.push_back(mk(1, 32'h500));
        smp();
        check("fl_rvalid", {31'b0, m_rvalid}, 1);
        check("fl_novalid", {31'b0, if_valid}, 0);
        check("fl_stall", {31'b0, if_stall}, 1);
        step(); smp();
        check("fl_reissue", {31'b0, m_req}, 1);
        check("fl_raddr", m_addr, 32'h500);
        step(); step(); smp();
        check("fl_valid", {31'b0, if_valid}, 1);
        step(); if_req = 0;

        // Reset while waiting for data
        mem_read = 1; mem_addr = 32'h600; smp();
        check("r_req", {31'b0, m_req}, 1);
        step(); rst = 1; mem_read = 0; smp();
        check("r_in_rst", {30'b0, m_req, mem_done}, 0);
        step(); rst = 0; smp();
        check("r_stray", {31'b0, m_rvalid}, 1);
        check("r_outs", {28'b0, m_req, mem_done, if_valid, mem_stall}, 0);
        check("r_rdata", mem_rdata, 0);

        // Continuous data traffic with a waiting fetch
        step();
        mem_read = 1; mem_addr = 32'h700; if_req = 1; if_addr = 32'h108;
`ifdef MEM_ARB_STARVE_GUARD_EN
        for (int i = 0; i < 4; i++) q.push_back(mk(0, 32'h700));
        q.push_back(mk(1, 32'h108));
        q.push_back(mk(0, 32'h700));
        fetch_exp = 12;
`else
        for (int i = 0; i < 6; i++) q.push_back(mk(0, 32'h700));
        fetch_exp = -1;
`endif
        fetch_cyc = -1;
        for (int c = 0; c < 18; c++) begin
            smp();
            if (m_req && m_ready && m_addr == 32'h108 && fetch_cyc < 0)
                fetch_cyc = c;
            step();
        end
        mem_read = 0; if_req = 0;
        check("s_fetch_cyc", fetch_cyc, fetch_exp);
        repeat (4) step();
        check("drain", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the single shared instruction/data memory port of the 5-stage RISC-V pipeline. It accepts fetch requests from IF and load/store requests from MEM (driven by the decoded `mem_read`/`mem_write` controls), serialises them onto one memory port with one outstanding transaction, and returns the stall signals that freeze the pipeline while a stage waits. Data accesses have priority; an optional starvation guard bounds fetch wait.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `STARVE_MAX`, 4: consecutive data grants with fetch pending before fetch is forced (guard only).

- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: IF wants an instruction word.
- `if_addr` in ADDR_W: fetch address (PC).
- `if_flush` in 1: branch taken; current or in-flight fetch is void.
- `if_rdata` out DATA_W: instruction word, valid with `if_valid`.
- `if_valid` out 1: fetch complete this cycle.
- `if_stall` out 1: `if_req & ~if_valid`.
- `mem_read`, `mem_write` in 1: MEM-stage load/store request (never both).
- `mem_addr` in ADDR_W; `mem_wdata` in DATA_W.
- `mem_rdata` out DATA_W: load data, valid with `mem_done`.
- `mem_done` out 1: load/store complete this cycle.
- `mem_stall` out 1: `(mem_read | mem_write) & ~mem_done`.
- `m_req` out 1; `m_we` out 1; `m_addr` out ADDR_W; `m_wdata` out DATA_W: memory request.
- `m_ready` in 1: memory accepts request when `m_req & m_ready`.
- `m_rvalid` in 1; `m_rdata` in DATA_W: response (also write ack).

## Operation
- FSM states: IDLE, WAIT_D, WAIT_I. Reset -> IDLE, drop flag 0, starve counter 0.
- IDLE: `d_pend = mem_read|mem_write`; `i_pend = if_req & ~if_flush`. Grant data if `d_pend` (unless guard forces fetch), else fetch if `i_pend`. `m_req` = grant exists; `m_addr/m_we/m_wdata` mux the granted requester (`m_we = mem_write` for data, 0 for fetch). On `m_req & m_ready` -> WAIT_D / WAIT_I; otherwise stay, re-arbitrate next cycle.
- WAIT_x: `m_req = 0`. On `m_rvalid` -> IDLE. In WAIT_D: `mem_done = 1`, `mem_rdata = m_rdata` (same cycle). In WAIT_I: `if_valid = ~drop & ~if_flush`, `if_rdata = m_rdata`.
- `if_flush` in WAIT_I sets drop; response consumed silently, drop cleared on leaving WAIT_I.
- `m_rvalid` in IDLE is ignored. Addresses/data pass unmodified; word access only.
- Reset mid-transaction: IDLE next cycle; late `m_rvalid` ignored; memory must be reset together.

## Timing
- All outputs combinational from state and inputs; state registered. Reset values: `m_req=0`, `if_valid=0`, `mem_done=0`, stalls follow requests.
- Read/write latency with `m_ready=1`, memory latency L: issue cycle 0, done cycle L; requester stalled L cycles, advances on the done edge.
- Done pulse and return to IDLE coincide, so the next issue is the cycle after done (one-cycle turnaround); no duplicate issue of a completed request.
- Simultaneous `d_pend` and `i_pend` in IDLE: data wins (guard aside).

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined: counter increments on each data grant while `i_pend`; clears on any fetch grant; at `STARVE_MAX` the next contested arbitration grants fetch.
- Undefined: strict data priority, no counter logic.

## Structure
- Shared package `mem_arb_pkg`: state enum (IDLE, WAIT_D, WAIT_I), `STARVE_MAX` default, requester-select constants.
- Optional sub-module `arb_starve_ctr` (counter + force flag), instantiated only under the macro.

## Test plan
- Lone fetch, addr 0x100, L=2, `m_ready=1` -> `m_req` cycle 0, `if_valid` cycle 2 with `if_rdata=m_rdata`, `if_stall` high cycles 0-1.
- `mem_read` 0x200 and `if_req` 0x104 same cycle -> data issued first, `mem_done` at L; fetch issued the cycle after, completes L later.
- `mem_write` 0x300 data 0xDEADBEEF, `m_ready` low 3 cycles -> `m_req` held with `m_we=1`, stable addr/data; `mem_done` L cycles after acceptance.
- `if_flush` during WAIT_I -> no `if_valid`; FSM to IDLE on `m_rvalid`; new fetch issued next cycle.
- `rst` in WAIT_D, stray `m_rvalid` after -> all outputs 0, no `mem_done`.
- Guard on, STARVE_MAX=4, continuous data requests plus `if_req` -> fetch granted after 4th data grant; guard off -> fetch never granted.
